// File: rtl/mem_lsu_pkg.sv
// Shared types and constants for the MEM-stage load/store unit.
package mem_lsu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RMW  = 1'b1
  } state_t;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;
  localparam int   DW      = 16;

endpackage

// File: rtl/mem_lsu_bytefmt.sv
// Byte-lane helper: extracts and extends a byte for loads, merges a byte into a word for RMW stores.
module mem_lsu_bytefmt
  import mem_lsu_pkg::*;
(
  input  logic [DW-1:0] ld_word,
  input  logic          ld_lane,
  input  logic          ld_sext,
  output logic [DW-1:0] ld_byte,
  input  logic [DW-1:0] mg_word,
  input  logic          mg_lane,
  input  logic [7:0]    mg_byte,
  output logic [DW-1:0] mg_out
);

  logic [7:0] sel;

  always_comb begin
    sel     = (ld_lane == LANE_LO) ? ld_word[7:0] : ld_word[15:8];
    ld_byte = {{8{ld_sext & sel[7]}}, sel};
    mg_out  = mg_word;
    if (mg_lane == LANE_HI) mg_out[15:8] = mg_byte;
    else                    mg_out[7:0]  = mg_byte;
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store initiator: word/byte loads (1-cycle latency), word stores, byte stores via 2-cycle RMW.
// Optional MEM_LSU_PERF_CNT_EN adds ld_cnt/st_cnt accepted-request counters.
module mem_lsu #(
  parameter int AW = 8,
  parameter int DW = 16,
  parameter int RW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic          req_byte,
  input  logic          req_sext,
  input  logic [AW:0]   req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [RW-1:0] req_rd,
  output logic          wb_valid,
  output logic [RW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          dwe,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata
`ifdef MEM_LSU_PERF_CNT_EN
  ,
  output logic [15:0]   ld_cnt,
  output logic [15:0]   st_cnt
`endif
);

  import mem_lsu_pkg::*;

  state_t        state, nxt;
  logic [DW-1:0] rmw_word, merged, ld_fmt;
  logic          rmw_lane;
  logic [7:0]    rmw_byte;
  logic [AW-1:0] rmw_addr, last_addr;
  logic [AW-1:0] req_word;
  logic          accept, ld_acc, st_acc;

  assign req_word  = req_addr[AW:1];
  assign req_ready = rst & (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign ld_acc    = accept & ~req_we;
  assign st_acc    = accept & req_we;

  mem_lsu_bytefmt u_fmt (
    .ld_word (rdata),
    .ld_lane (req_addr[0]),
    .ld_sext (req_sext),
    .ld_byte (ld_fmt),
    .mg_word (rmw_word),
    .mg_lane (rmw_lane),
    .mg_byte (rmw_byte),
    .mg_out  (merged)
  );

  always_comb begin
    nxt   = state;
    dwe   = 1'b0;
    addr  = last_addr;
    wdata = '0;
    case (state)
      IDLE: if (accept) begin
        addr = req_word;
        if (req_we && !req_byte) begin
          dwe   = 1'b1;
          wdata = req_wdata;
        end
        if (req_we && req_byte) nxt = RMW;
      end
      RMW: begin
        dwe   = 1'b1;
        addr  = rmw_addr;
        wdata = merged;
        nxt   = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Async reset in RMW drops the pending write: state leaves RMW immediately, so dwe falls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      last_addr <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      rmw_word  <= '0;
      rmw_lane  <= 1'b0;
      rmw_byte  <= '0;
      rmw_addr  <= '0;
    end else begin
      state     <= nxt;
      last_addr <= addr;
      wb_valid  <= ld_acc;
      if (ld_acc) begin
        wb_rd   <= req_rd;
        wb_data <= req_byte ? ld_fmt : rdata;
      end
      if (st_acc && req_byte) begin
        rmw_word <= rdata;
        rmw_lane <= req_addr[0];
        rmw_byte <= req_wdata[7:0];
        rmw_addr <= req_word;
      end
    end
  end

`ifdef MEM_LSU_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_cnt <= '0;
      st_cnt <= '0;
    end else begin
      ld_cnt <= ld_cnt + 16'(ld_acc);
      st_cnt <= st_cnt + 16'(st_acc);
    end
  end
`endif

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
- Load/store initiator for the MEM stage of the 16-bit pipeline CPU.
- Accepts load/store requests from EX over a valid/ready handshake.
- Drives the word-addressed data memory port (dwe, addr, wdata; combinational rdata, write on clk posedge).
- Returns load data to WB. Supports 16-bit word and 8-bit byte accesses; byte stores use a 2-cycle read-modify-write.

Parameters:
- AW, 8, data memory word-address width.
- DW, 16, data width; fixed at 16 (byte lanes assume 2 bytes/word).
- RW, 3, register-index width carried to WB.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  EX request valid.
- req_ready  out  1  LSU can accept this cycle.
- req_we  in  1  1=store, 0=load.
- req_byte  in  1  1=byte access, 0=word access.
- req_sext  in  1  byte load sign-extend (ignored otherwise).
- req_addr  in  AW+1  byte address; [AW:1]=word, [0]=lane (0=low byte [7:0]).
- req_wdata  in  DW  store data; byte store uses [7:0].
- req_rd  in  RW  load destination register.
- wb_valid  out  1  load result valid (1-cycle pulse).
- wb_rd  out  RW  destination register.
- wb_data  out  DW  load result.
- dwe  out  1  memory write enable.
- addr  out  AW  memory word address.
- wdata  out  DW  memory write data.
- rdata  in  DW  memory read data (combinational from addr).

Behaviour:
- Reset (rst low, async): state=IDLE; wb_valid=0, wb_rd=0, wb_data=0; dwe=0; addr=0; wdata=0. req_ready=1 once rst is released.
- Memory outputs (dwe, addr, wdata) are combinational from state and request; memory samples them on the clk posedge.
- FSM states: IDLE, RMW.
- IDLE, req_valid=1: the request is accepted on the clk edge (req_ready=1).
  - Word store: dwe=1, addr=req_addr[AW:1], wdata=req_wdata. Completes in 1 cycle; stay IDLE.
  - Load (word or byte): dwe=0, addr=req_addr[AW:1]. rdata is registered at the edge; wb_valid=1 in the next cycle (latency 1). Stay IDLE, so back-to-back loads give 1 result per cycle.
  - Byte store: dwe=0, addr=word. Latch rdata, lane, byte, and word address. Go to RMW.
- RMW (1 cycle): req_ready=0.
  - dwe=1, addr=latched word.
  - wdata = latched rdata with the selected lane replaced by the latched byte.
  - Return to IDLE. A request held valid during RMW is accepted on the following cycle.
- Load formatting:
  - Word load: wb_data=rdata.
  - Byte load: select the lane. Upper 8 bits are 0, or copies of bit 7 of the selected byte when req_sext=1.
- wb_valid is 0 in any cycle with no load accepted in the previous cycle. wb_rd and wb_data hold their last values when wb_valid=0.
- Store followed by load to the same word: the store writes at edge N; the load in cycle N+1 reads the new data. No forwarding is needed.
- Address wrap: the word address is taken modulo 2^AW; there is no misalignment fault (lane bit is always legal).
- Reset in RMW: the pending write is dropped, state goes to IDLE, and memory is not written.
- req_valid=0: dwe=0. addr holds the last value (don't care).

Optional Feature:
- Macro: MEM_LSU_PERF_CNT_EN.
- Defined: adds outputs ld_cnt and st_cnt (16 bits each, wrapping). They increment on each accepted load and each accepted store respectively (byte store counts once). Both reset to 0.
- Undefined: no counters and no extra ports; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=1'b0, RMW=1'b1.
  - Lane constants: LANE_LO=0, LANE_HI=1.
  - Data width constant DW=16.
- One natural sub-module: mem_lsu_bytefmt. It is combinational: lane extract with zero/sign extend for loads, and lane merge for RMW.
- The FSM and registers stay in mem_lsu.

Test Plan:
- Reset load: preload mem[1]=16'h0018. Load word, req_addr=9'h002 -> next cycle wb_valid=1, wb_data=16'h0018, wb_rd matches req_rd.
- Word store then load: store 16'hBEEF to byte addr 9'h00A, then load the same address the next cycle -> wb_data=16'hBEEF. dwe high for exactly 1 cycle.
- Byte store RMW: mem[2]=16'h0020. Store byte 8'hA5 to 9'h005 -> req_ready=0 for 1 cycle; mem[2]=16'hA520; 2 total cycles.
- Byte load sign/zero: mem[3]=16'h80F0. Load byte at 9'h007 with sext=1 -> 16'hFF80. Load byte at 9'h006 with sext=0 -> 16'h00F0.
- Back-to-back plus wrap: continuous loads at 9'h1FE, 9'h000, 9'h002 -> three consecutive wb_valid pulses with the correct data. addr wraps 8'hFF -> 8'h00.
- Reset mid-RMW: assert rst low in the RMW cycle -> mem word unchanged; wb_valid=0, dwe=0; req_ready=1 after release.
